// File: rtl/multi_channel_logger.sv
// Multi-channel sample logger: per-channel block averaging into a small FIFO
// that drains to a memory writer, in one-shot or circular addressing mode.
module multi_channel_logger #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 10,
    parameter int STORE_W    = 8,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15,
    parameter int MEM_WORDS  = 32768,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int FIFO_LW   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               circular,
    input  logic               smp_valid,
    input  logic [CH_W-1:0]    smp_ch,
    input  logic [SAMPLE_W-1:0] smp_data,
    output logic [STORE_W-1:0] wr_data,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic               mem_full,
    output logic [7:0]         overflow_cnt,
    output logic [FIFO_LW-1:0] fifo_level
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SHIFT = AVG_LOG2 + SAMPLE_W - STORE_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CH_W:0]        NUM_CH_L  = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(MEM_WORDS - 1);
    localparam logic [FIFO_LW-1:0]   LVL_FULL  = FIFO_LW'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [STORE_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [STORE_W-1:0] fifo_mem_d [FIFO_DEPTH];

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_LW-1:0] level_q, level_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               mem_full_q, mem_full_d;
    logic [7:0]         ovf_q, ovf_d;
    logic [STORE_W-1:0] last_q, last_d;

    logic               accept;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               valid;
    logic [CH_W-1:0]    ch_idx;
    logic [ACC_W-1:0]   sum;
    logic [STORE_W-1:0] result;

    assign valid = (level_q != '0) && !mem_full_q;
    assign pop   = valid && wr_ready;

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        addr_d     = addr_q;
        mem_full_d = mem_full_q;
        ovf_d      = ovf_q;
        last_d     = last_q;
        push       = 1'b0;
        push_ok    = 1'b0;

        accept = smp_valid && enable && !mem_full_q && ({1'b0, smp_ch} < NUM_CH_L);
        ch_idx = accept ? smp_ch : '0;
        sum    = acc_q[ch_idx] + ACC_W'(smp_data);
        result = STORE_W'(sum >> SHIFT);

        // The final sample of a block is folded in combinationally so the
        // average is pushed on the same edge that clears the accumulator.
        if (accept) begin
            if (cnt_q[ch_idx] == CNT_LAST) begin
                acc_d[ch_idx] = '0;
                cnt_d[ch_idx] = '0;
                push          = 1'b1;
            end else begin
                acc_d[ch_idx] = sum;
                cnt_d[ch_idx] = cnt_q[ch_idx] + CNT_W'(1);
            end
        end

        push_ok = push && ((level_q != LVL_FULL) || pop);
        if (push && !push_ok && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = result;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            last_d   = fifo_mem_q[rd_ptr_q];
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            if (addr_q == ADDR_LAST) begin
                if (circular) begin
                    addr_d = '0;
                end else begin
                    mem_full_d = 1'b1;
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        level_d = level_q + FIFO_LW'(push_ok) - FIFO_LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            addr_q     <= '0;
            mem_full_q <= 1'b0;
            ovf_q      <= '0;
            last_q     <= '1;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            addr_q     <= addr_d;
            mem_full_q <= mem_full_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
        end
    end

    // Storage cells need no reset: an empty level masks stale contents.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign wr_valid     = valid;
    assign wr_data      = (level_q != '0) ? fifo_mem_q[rd_ptr_q] : last_q;
    assign wr_addr      = addr_q;
    assign mem_full     = mem_full_q;
    assign overflow_cnt = ovf_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_multi_channel_logger.sv
// Bench for multi_channel_logger: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_channel_logger;

    localparam int NCH   = 4;
    localparam int MW    = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, enable, circular, smp_valid, wr_ready;
    logic [1:0]  smp_ch;
    logic [9:0]  smp_data;
    logic [7:0]  wr_data;
    logic [14:0] wr_addr;
    logic        wr_valid, mem_full;
    logic [7:0]  overflow_cnt;
    logic [3:0]  fifo_level;

    multi_channel_logger #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .circular(circular),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .mem_full(mem_full),
        .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: per-channel running sums, word queue, address counter.
    int         m_sum [NCH];
    int         m_n   [NCH];
    logic [7:0] m_fifo [$];
    int         m_addr, m_ovf;
    bit         m_full;
    logic [7:0] m_last;
    bit         m_pop, m_push;
    int         m_pre, m_res;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_sum[i] = 0;
                m_n[i]   = 0;
            end
            m_fifo.delete();
            m_addr = 0; m_ovf = 0; m_full = 0; m_last = 8'hFF;
        end else begin
            m_pre  = m_fifo.size();
            m_pop  = (m_pre != 0) && !m_full && wr_ready;
            m_push = 0;
            if (smp_valid && enable && !m_full && int'(smp_ch) < NCH) begin
                m_sum[smp_ch] += int'(smp_data);
                m_n[smp_ch]++;
                if (m_n[smp_ch] == 4) begin
                    m_res = m_sum[smp_ch] / 16;
                    m_sum[smp_ch] = 0;
                    m_n[smp_ch]   = 0;
                    m_push = 1;
                end
            end
            if (m_pop) begin
                m_last = m_fifo.pop_front();
                if (m_addr == MW - 1) begin
                    if (circular) m_addr = 0;
                    else          m_full = 1;
                end else begin
                    m_addr++;
                end
            end
            if (m_push) begin
                if (m_pre < DEPTH || m_pop) m_fifo.push_back(m_res[7:0]);
                else if (m_ovf < 255)       m_ovf++;
            end
        end
    end

    bit exp_valid;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_valid = (m_fifo.size() != 0) && !m_full;
            chk("wr_valid", int'(wr_valid), int'(exp_valid));
            chk("fifo_level", int'(fifo_level), m_fifo.size());
            chk("wr_addr", int'(wr_addr), m_addr);
            chk("mem_full", int'(mem_full), int'(m_full));
            chk("overflow_cnt", int'(overflow_cnt), m_ovf);
            if (exp_valid)                chk("wr_data", int'(wr_data), int'(m_fifo[0]));
            else if (m_fifo.size() == 0) chk("wr_data_hold", int'(wr_data), int'(m_last));
        end
    end

    task automatic cyc(input bit v, input int ch, input int d);
        smp_valid = v;
        smp_ch    = ch[1:0];
        smp_data  = d[9:0];
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        smp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1;
    endtask

    task automatic averages(input int n, input int ch);
        for (int i = 0; i < 4 * n; i++) cyc(1'b1, ch, int'($urandom_range(0, 1023)));
        smp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; circular = 1'b0; smp_valid = 1'b0;
        wr_ready = 1'b1; smp_ch = '0; smp_data = '0;
        @(negedge clk);
        do_reset();
        chk("rst_valid", int'(wr_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_data", int'(wr_data), 'hFF);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_full", int'(mem_full), 0);
        chk("rst_ovf", int'(overflow_cnt), 0);

        // Four full-scale samples on ch0 average to 0xFF.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 0, 'h3FF);
            chk("avg_pending_valid", int'(wr_valid), 0);
        end
        cyc(1'b1, 0, 'h3FF);
        chk("avg_valid", int'(wr_valid), 1);
        chk("avg_data", int'(wr_data), 'hFF);
        chk("avg_addr", int'(wr_addr), 0);
        cyc(1'b0, 0, 0);
        chk("avg_after_addr", int'(wr_addr), 1);
        chk("avg_after_valid", int'(wr_valid), 0);

        // Interleaved channels: ch1 (1000/16 = 0x3E) completes first.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1, 100 * i);
            if (i == 4) begin
                chk("il_ch1_data", int'(wr_data), 'h3E);
                chk("il_ch1_addr", int'(wr_addr), 0);
            end
            cyc(1'b1, 0, 'h3FF);
        end
        chk("il_ch0_data", int'(wr_data), 'hFF);
        chk("il_ch0_addr", int'(wr_addr), 1);
        cyc(1'b0, 0, 0);

        // Back-pressure: nine averages into eight entries.
        do_reset();
        wr_ready = 1'b0;
        averages(9, 2);
        cyc(1'b0, 0, 0);
        chk("bp_level", int'(fifo_level), 8);
        chk("bp_ovf", int'(overflow_cnt), 1);
        wr_ready = 1'b1;
        repeat (12) cyc(1'b0, 0, 0);
        chk("bp_drain_addr", int'(wr_addr), 8);
        chk("bp_drain_level", int'(fifo_level), 0);

        // One-shot fill stops at the last address.
        do_reset();
        circular = 1'b0;
        averages(MW + 1, 3);
        repeat (5) cyc(1'b0, 0, 0);
        chk("os_full", int'(mem_full), 1);
        chk("os_addr", int'(wr_addr), MW - 1);
        chk("os_valid", int'(wr_valid), 0);
        circular = 1'b1;
        cyc(1'b0, 0, 0);
        chk("os_full_sticky", int'(mem_full), 1);

        // Circular mode wraps: 17 transfers end with the address at 1.
        do_reset();
        circular = 1'b1;
        averages(MW + 1, 1);
        repeat (5) cyc(1'b0, 0, 0);
        chk("circ_full", int'(mem_full), 0);
        chk("circ_addr", int'(wr_addr), 1);

        // Reset discards buffered words.
        do_reset();
        wr_ready = 1'b0;
        averages(3, 0);
        cyc(1'b0, 0, 0);
        chk("rb_level", int'(fifo_level), 3);
        do_reset();
        chk("rb_valid", int'(wr_valid), 0);
        chk("rb_level0", int'(fifo_level), 0);
        chk("rb_data", int'(wr_data), 'hFF);
        chk("rb_addr", int'(wr_addr), 0);
        wr_ready = 1'b1;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) circular = ~circular;
            rst      = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1023)));
        end
        rst = 1'b0;
        repeat (4) cyc(1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
